// File: rtl/soc_system_pio_cmd.sv
// Avalon-MM command PIO: atomic set/clear, self-clearing pulse bits with a shared
// retriggerable timer, and synchronised ack inputs with edge capture and maskable irq.
module soc_system_pio_cmd #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      PULSE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_ack,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int unsigned   CW     = (PULSE_CYCLES > 0) ? $clog2(PULSE_CYCLES + 1) : 1;
    localparam int unsigned   LOAD_I = (PULSE_CYCLES > 0) ? PULSE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LOAD   = CW'(LOAD_I);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_nx;
    logic [CW-1:0]    r_count, w_count_nx;
    logic [WIDTH-1:0] r_data, w_data_nx, w_data_wr;
    logic [WIDTH-1:0] r_pulse_mask, r_irq_mask;
    logic [WIDTH-1:0] r_edge, w_edge_nx;
    logic [WIDTH-1:0] r_sync1, r_sync2, r_ack_d;
    logic [WIDTH-1:0] w_wd, w_rise;
    logic             w_wr, w_trig, w_expire;

    assign w_wr   = chipselect & ~write_n;
    assign w_wd   = writedata[WIDTH-1:0];
    assign w_rise = r_sync2 & ~r_ack_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_data       <= RESET_VALUE;
            r_pulse_mask <= '0;
            r_irq_mask   <= '0;
            r_edge       <= '0;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_ack_d      <= '0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_data  <= w_data_nx;
            r_edge  <= w_edge_nx;
            r_sync1 <= in_ack;
            r_sync2 <= r_sync1;
            r_ack_d <= r_sync2;
            if (w_wr && address == 3'd1) r_pulse_mask <= w_wd;
            if (w_wr && address == 3'd6) r_irq_mask   <= w_wd;
        end
    end

    always_comb begin
        w_data_wr  = r_data;
        w_state_nx = r_state;
        w_count_nx = r_count;
        if (w_wr) begin
            case (address)
                3'd0:    w_data_wr = w_wd;
                3'd4:    w_data_wr = r_data | w_wd;
                3'd5:    w_data_wr = r_data & ~w_wd;
                default: w_data_wr = r_data;
            endcase
        end
        w_trig   = (PULSE_CYCLES > 0) && w_wr && (address == 3'd0 || address == 3'd4)
                   && |(w_data_wr & r_pulse_mask);
        w_expire = (r_state == S_RUN) && (r_count == '0);
        w_data_nx = w_data_wr;
        // A triggering write in the expiry cycle takes priority over the clear.
        if (w_trig) begin
            w_state_nx = S_RUN;
            w_count_nx = LOAD;
        end else if (w_expire) begin
            w_state_nx = S_IDLE;
            w_data_nx  = w_data_wr & ~r_pulse_mask;
        end else if (r_state == S_RUN) begin
            w_count_nx = r_count - 1'b1;
        end
    end

    // New rising edge beats a simultaneous W1C of the same bit.
    always_comb begin
        w_edge_nx = r_edge;
        if (w_wr && address == 3'd3) w_edge_nx = r_edge & ~w_wd;
        w_edge_nx = w_edge_nx | w_rise;
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[WIDTH-1:0] = r_data;
            3'd1:    readdata[WIDTH-1:0] = r_pulse_mask;
            3'd2:    readdata[0]         = (r_state == S_RUN);
            3'd3:    readdata[WIDTH-1:0] = r_edge;
            3'd6:    readdata[WIDTH-1:0] = r_irq_mask;
            default: readdata = '0;
        endcase
    end

    assign out_port = r_data;
    assign irq      = |(r_edge & r_irq_mask);

endmodule

// File: tb/tb_soc_system_pio_cmd.sv
// Directed self-checking bench for soc_system_pio_cmd (WIDTH=8, PULSE_CYCLES=4, RESET_VALUE=A5).
module tb_soc_system_pio_cmd;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_ack;
    logic [7:0]  out_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    soc_system_pio_cmd #(
        .WIDTH       (8),
        .PULSE_CYCLES(4),
        .RESET_VALUE (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_ack    (in_ack),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write sampled at the next rising edge; returns 1 time unit after that edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [8];
        logic [31:0] v;
        exp_rd = '{32'hA5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL reset_out_port: got %h expected a5", out_port);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            checks++;
            if (v !== exp_rd[i]) begin
                errors++;
                $display("FAIL reset_read_addr%0d: got %h expected %h", i, v, exp_rd[i]);
            end
        end
    endtask

    task automatic test_set_clear();
        logic [31:0] v;
        wr(3'd0, 32'h0F);
        checks++;
        if (out_port !== 8'h0F) begin
            errors++;
            $display("FAIL data_write: got %h expected 0f", out_port);
        end
        wr(3'd4, 32'h30);
        checks++;
        if (out_port !== 8'h3F) begin
            errors++;
            $display("FAIL outset: got %h expected 3f", out_port);
        end
        wr(3'd5, 32'h03);
        checks++;
        if (out_port !== 8'h3C) begin
            errors++;
            $display("FAIL outclear: got %h expected 3c", out_port);
        end
        rd(3'd4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL outset_reads_zero: got %h expected 0", v);
        end
        wr(3'd6, 32'hFFFFFF5A);
        rd(3'd6, v);
        checks++;
        if (v !== 32'h5A) begin
            errors++;
            $display("FAIL irq_mask_readback: got %h expected 5a", v);
        end
        wr(3'd6, 32'h0);
    endtask

    task automatic test_pulse();
        logic [31:0] v;
        wr(3'd1, 32'h01);
        rd(3'd1, v);
        checks++;
        if (v !== 32'h01) begin
            errors++;
            $display("FAIL pulse_mask_readback: got %h expected 01", v);
        end
        wr(3'd0, 32'h81);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            rd(3'd2, v);
            checks++;
            if (out_port !== ((k < 4) ? 8'h81 : 8'h80)) begin
                errors++;
                $display("FAIL pulse_out_c%0d: got %h expected %h", k, out_port,
                         (k < 4) ? 8'h81 : 8'h80);
            end
            checks++;
            if (v !== ((k < 4) ? 32'h1 : 32'h0)) begin
                errors++;
                $display("FAIL pulse_status_c%0d: got %h expected %h", k, v,
                         (k < 4) ? 32'h1 : 32'h0);
            end
        end
    endtask

    task automatic test_retrigger();
        wr(3'd4, 32'h01);
        tick();
        wr(3'd4, 32'h01);
        for (int k = 2; k < 8; k++) begin
            if (k > 2) tick();
            checks++;
            if (out_port[0] !== ((k < 6) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL retrig_bit0_c%0d: got %b expected %b", k, out_port[0], k < 6);
            end
        end
        wr(3'd4, 32'h01);
        repeat (3) tick();
        wr(3'd4, 32'h01);
        for (int k = 4; k < 10; k++) begin
            if (k > 4) tick();
            checks++;
            if (out_port[0] !== ((k < 8) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL expiry_write_bit0_c%0d: got %b expected %b", k, out_port[0], k < 8);
            end
        end
    endtask

    task automatic test_ack_edge();
        logic [31:0] v;
        int cyc;
        wr(3'd6, 32'h04);
        in_ack = 8'h04;
        cyc = 0;
        v = '0;
        while (cyc < 4 && v !== 32'h04) begin
            tick();
            cyc++;
            rd(3'd3, v);
        end
        checks++;
        if (v !== 32'h04 || cyc > 3) begin
            errors++;
            $display("FAIL edge_capture: got %h after %0d cycles expected 04 within 3", v, cyc);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b expected 1", irq);
        end
        wr(3'd3, 32'h04);
        rd(3'd3, v);
        checks++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: got edge %h irq %b expected 0 0", v, irq);
        end
        in_ack = 8'h00;
        repeat (4) tick();
        rd(3'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL falling_no_edge: got %h expected 0", v);
        end
        in_ack = 8'h04;
        repeat (2) tick();
        wr(3'd3, 32'h04);
        rd(3'd3, v);
        checks++;
        if (v !== 32'h04 || irq !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_w1c: got edge %h irq %b expected 04 1", v, irq);
        end
        wr(3'd6, 32'h00);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_clear_irq: got %b expected 0", irq);
        end
        wr(3'd6, 32'h04);
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] v;
        wr(3'd0, 32'h01);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(3'd2, v);
        checks++;
        if (out_port !== 8'hA5 || v !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pulse: got out %h status %h irq %b expected a5 0 0",
                     out_port, v, irq);
        end
        wr(3'd1, 32'h01);
        for (int k = 0; k < 6; k++) begin
            tick();
            rd(3'd2, v);
            checks++;
            if (out_port !== 8'hA5 || v !== 32'h0) begin
                errors++;
                $display("FAIL no_residual_c%0d: got out %h status %h expected a5 0",
                         k, out_port, v);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_ack     = '0;
        test_reset();
        test_set_clear();
        test_pulse();
        test_retrigger();
        test_ack_edge();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
